touch_sample_ctrl: RTL and testbench

- Parametrised successor to the single-shot touch controller; sits between the touch-panel IRQ pin and the SPI/byte function module, which it drives over an oCall/iDone/iData handshake.
- Adds IRQ synchronisation and debounce, N-channel acquisition, power-of-two sample averaging, continuous periodic sampling while the pen is down, and pen-down/pen-up reporting.

---
 rtl/touch_sample_ctrl_if.sv | 12 +
 rtl/touch_sample_ctrl.sv | 166 ++++++++++++++++
 tb/tb_touch_sample_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/touch_sample_ctrl_if.sv
// Request/response link between the touch sampler and the SPI/byte function module.
interface touch_sample_ctrl_if #(
  parameter int NCH = 2,
  parameter int DW  = 8
);
  logic [NCH-1:0] oCall;   // one-hot channel request
  logic           iDone;   // single-cycle completion pulse
  logic [DW-1:0]  iData;   // channel byte, valid with iDone

  modport master (output oCall, input iDone, input iData);
  modport slave  (input oCall, output iDone, output iData);
endinterface

// File: rtl/touch_sample_ctrl.sv
// Touch-panel sampler: IRQ sync + debounce, N-channel averaged acquisition,
// periodic resampling while the pen is held, pen-down/pen-up reporting.
module touch_sample_ctrl #(
  parameter int NCH      = 2,
  parameter int DW       = 8,
  parameter int AVG_LOG2 = 2,
  parameter int DEB_CYC  = 1000,
  parameter int INTERVAL = 50000
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  TP_IRQ,
  input  logic                  iEn,
  touch_sample_ctrl_if.master   bus,
  output logic                  oDone,
  output logic [NCH*DW-1:0]     oData,
  output logic                  oPenDown,
  output logic                  oPenUp
);
  localparam int AW  = DW + AVG_LOG2;                 // sum of 2^AVG_LOG2 bytes fits
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int DBW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int WTW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  localparam logic [CHW-1:0] CH_TOP   = CHW'(NCH - 1);
  localparam logic [RW-1:0]  RND_TOP  = RW'((1 << AVG_LOG2) - 1);
  localparam logic [DBW-1:0] DEB_LAST = DBW'(DEB_CYC - 1);
  localparam logic [WTW-1:0] WT_LAST  = WTW'(INTERVAL - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DEB, ST_CALL, ST_OUT, ST_WAIT
  } state_t;

  state_t                    r_st;
  logic                      r_irq_m, r_irq_s;
  logic [DBW-1:0]            r_deb;
  logic [WTW-1:0]            r_wt;
  logic [CHW-1:0]            r_ch;
  logic [RW-1:0]             r_round;
  logic                      r_rel;
  logic [NCH-1:0]            r_call;
  logic [NCH-1:0][AW-1:0]    r_acc;
  logic [NCH-1:0]            w_onehot;
  logic [NCH*DW-1:0]         w_res;

  assign bus.oCall = r_call;

  // One-hot decode of the channel currently being requested
  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < NCH; k++) w_onehot[k] = (r_ch == CHW'(k));
  end

  // Per-channel mean: drop the AVG_LOG2 fraction bits (truncating)
  for (genvar k = 0; k < NCH; k++) begin : g_res
    assign w_res[k*DW +: DW] = r_acc[k][AW-1:AVG_LOG2];
    if (AVG_LOG2 > 0) begin : g_lo
      logic w_unused_lo;
      assign w_unused_lo = ^r_acc[k][AVG_LOG2-1:0];
    end
  end

  // Two-flop synchroniser; resets to the released (high) level
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_irq_m <= 1'b1;
      r_irq_s <= 1'b1;
    end else begin
      r_irq_m <= TP_IRQ;
      r_irq_s <= r_irq_m;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_st     <= ST_IDLE;
      r_deb    <= '0;
      r_wt     <= '0;
      r_ch     <= '0;
      r_round  <= '0;
      r_rel    <= 1'b0;
      r_call   <= '0;
      r_acc    <= '0;
      oDone    <= 1'b0;
      oData    <= '0;
      oPenDown <= 1'b0;
      oPenUp   <= 1'b0;
    end else begin
      oDone  <= 1'b0;
      oPenUp <= 1'b0;
      case (r_st)
        ST_IDLE: begin
          r_deb <= '0;
          if (iEn && !r_irq_s) r_st <= ST_DEB;
        end
        ST_DEB: begin
          if (r_irq_s || !iEn) begin
            r_deb <= '0;
            r_st  <= ST_IDLE;
          end else if (r_deb == DEB_LAST) begin
            r_deb    <= '0;
            oPenDown <= 1'b1;
            r_acc    <= '0;
            r_rel    <= 1'b0;
            r_ch     <= CH_TOP;
            r_round  <= '0;
            r_st     <= ST_CALL;
          end else begin
            r_deb <= r_deb + 1'b1;
          end
        end
        ST_CALL: begin
          // Release is only noted here; the set is discarded at OUT
          if (r_irq_s) r_rel <= 1'b1;
          if (r_call == '0) begin
            r_call <= w_onehot;              // one idle cycle before each request
          end else if (bus.iDone) begin
            r_call       <= '0;
            r_acc[r_ch]  <= r_acc[r_ch] + AW'(bus.iData);
            if (r_ch != '0) begin
              r_ch <= r_ch - 1'b1;
            end else begin
              r_ch    <= CH_TOP;
              r_round <= r_round + 1'b1;
              if (r_round == RND_TOP) r_st <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (!r_rel) begin
            oData <= w_res;
            oDone <= 1'b1;
            r_wt  <= '0;
            r_st  <= ST_WAIT;
          end else begin
            oPenUp   <= 1'b1;
            oPenDown <= 1'b0;
            r_st     <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (r_irq_s) begin
            oPenUp   <= 1'b1;
            oPenDown <= 1'b0;
            r_st     <= ST_IDLE;
          end else if (!iEn) begin
            oPenDown <= 1'b0;                // disable is not a pen release
            r_st     <= ST_IDLE;
          end else if (r_wt == WT_LAST) begin
            r_wt    <= '0;
            r_acc   <= '0;
            r_rel   <= 1'b0;
            r_ch    <= CH_TOP;
            r_round <= '0;
            r_st    <= ST_CALL;
          end else begin
            r_wt <= r_wt + 1'b1;
          end
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_touch_sample_ctrl.sv
// Bench for touch_sample_ctrl: table sets plus random sets against an averaging model.
module tb_touch_sample_ctrl;
  logic        CLOCK = 1'b0;
  logic        RESET, TP_IRQ, iEn;
  logic        oDone, oPenDown, oPenUp;
  logic [15:0] oData;

  touch_sample_ctrl_if #(.NCH(2), .DW(8)) bus();

  touch_sample_ctrl #(.NCH(2), .DW(8), .AVG_LOG2(2), .DEB_CYC(4), .INTERVAL(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .TP_IRQ(TP_IRQ), .iEn(iEn), .bus(bus),
    .oDone(oDone), .oData(oData), .oPenDown(oPenDown), .oPenUp(oPenUp)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [3:0][7:0] d1;    // ch1 bytes, element 0 returned first
    logic [3:0][7:0] d0;
    logic [15:0]     exp;
  } vec_t;

  int          checks = 0, errors = 0;
  int          done_cnt = 0, pu_cnt = 0;
  logic [7:0]  q1[$], q0[$];
  logic [1:0]  req_log[$];
  vec_t        tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge CLOCK); #1; end
  endtask

  // Mean of four bytes per channel, packed {ch1, ch0}
  function automatic logic [15:0] model(input vec_t v);
    int s1 = 0, s0 = 0;
    for (int i = 0; i < 4; i++) begin s1 += v.d1[i]; s0 += v.d0[i]; end
    return {8'(s1 / 4), 8'(s0 / 4)};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      v.d1[i] = 8'($urandom_range(0, 255));
      v.d0[i] = 8'($urandom_range(0, 255));
    end
    v.exp = model(v);
    return v;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < 4; i++) begin q1.push_back(v.d1[i]); q0.push_back(v.d0[i]); end
  endtask

  task automatic cyc_to_call(output int n);
    n = 0;
    do begin tick(); n++; end while (bus.oCall == 2'b00 && n < 60);
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    ok = 0;
    while (n < 300 && !ok) begin tick(); n++; if (oDone) ok = 1; end
  endtask

  task automatic check_set(input string nm, input logic [15:0] exp, input int base);
    bit ok, good;
    wait_done(ok);
    chk({nm, " done"}, 32'(ok), 1);
    chk({nm, " data"}, oData, exp);
    chk({nm, " pendown"}, oPenDown, 1);
    chk({nm, " reqs"}, req_log.size() - base, 8);
    good = 1;
    for (int i = 0; i < 8; i++)
      if (base + i >= req_log.size() || req_log[base+i] != ((i % 2 == 0) ? 2'b10 : 2'b01)) good = 0;
    chk({nm, " order"}, 32'(good), 1);
  endtask

  // Function-module model: iDone three cycles after oCall rises
  initial begin
    logic [1:0] c;
    bus.iDone = 1'b0;
    bus.iData = 8'h00;
    forever begin
      @(posedge CLOCK); #1;
      if (bus.oCall != 2'b00) begin
        c = bus.oCall;
        req_log.push_back(c);
        @(posedge CLOCK); @(posedge CLOCK); #1;
        bus.iDone = 1'b1;
        if (c[1]) bus.iData = (q1.size() > 0) ? q1.pop_front() : 8'h00;
        else      bus.iData = (q0.size() > 0) ? q0.pop_front() : 8'h00;
        @(posedge CLOCK); #1;
        bus.iDone = 1'b0;
      end
    end
  end

  // Pulse counters, sampled on the falling edge
  initial forever begin
    @(negedge CLOCK);
    if (oDone)  done_cnt++;
    if (oPenUp) pu_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t        cur;
    int          n, base, dc, pc, sz;
    bit          ok;
    logic [15:0] last;

    tbl[0].d1 = {8'd13, 8'd12, 8'd11, 8'd10};  tbl[0].d0 = {8'd203, 8'd202, 8'd201, 8'd200};
    tbl[0].exp = 16'h0BC9;
    tbl[1].d1 = {4{8'd255}};                   tbl[1].d0 = {4{8'd255}};
    tbl[1].exp = 16'hFFFF;
    tbl[2].d1 = {8'd3, 8'd0, 8'd0, 8'd0};       tbl[2].d0 = {8'd5, 8'd3, 8'd2, 8'd1};
    tbl[2].exp = 16'h0002;
    tbl[3].d1 = {4{8'd7}};                     tbl[3].d0 = {8'd11, 8'd10, 8'd9, 8'd8};
    tbl[3].exp = 16'h0709;

    RESET = 1'b0; TP_IRQ = 1'b1; iEn = 1'b0;
    tick(2);
    chk("reset oCall", bus.oCall, 0);
    chk("reset oDone", oDone, 0);
    chk("reset oData", oData, 0);
    chk("reset oPenDown", oPenDown, 0);
    chk("reset oPenUp", oPenUp, 0);
    RESET = 1'b1;
    tick(2);

    // Glitch shorter than the debounce window
    iEn = 1'b1; TP_IRQ = 1'b0;
    tick(3);
    TP_IRQ = 1'b1;
    tick(20);
    chk("glitch pendown", oPenDown, 0);
    chk("glitch no call", req_log.size(), 0);

    // Press and hold: 2 sync + 1 IDLE->DEBOUNCE + 4 debounce + 1 CALL entry = 8
    cur = tbl[0];
    load(cur);
    base = req_log.size();
    TP_IRQ = 1'b0;
    cyc_to_call(n);
    chk("press latency", n, 8);

    // Continuous sets while held; oCall rises 8 cycles after the oDone pulse ends
    for (int i = 0; i < 10; i++) begin
      check_set($sformatf("set%0d", i), cur.exp, base);
      base = req_log.size();
      if (i < 9) begin
        cur = (i + 1 < 4) ? tbl[i+1] : rand_vec();
        load(cur);
        cyc_to_call(n);
        chk($sformatf("interval%0d", i), n, 9);
      end
    end
    tick(1);
    chk("done pulses", done_cnt, 10);

    // Release during the second round of a set
    last = oData; dc = done_cnt; pc = pu_cnt;
    n = 0;
    while (req_log.size() < base + 3 && n < 200) begin tick(); n++; end
    chk("reach round2", 32'(req_log.size() >= base + 3), 1);
    TP_IRQ = 1'b1;
    n = 0;
    while (!oPenUp && n < 200) begin tick(); n++; end
    chk("rel penup seen", oPenUp, 1);
    sz = req_log.size();
    tick(40);
    chk("rel penup once", pu_cnt - pc, 1);
    chk("rel no done", done_cnt - dc, 0);
    chk("rel data kept", oData, last);
    chk("rel pendown", oPenDown, 0);
    chk("rel no more call", req_log.size() - sz, 0);
    chk("rel oCall idle", bus.oCall, 0);

    // Release during WAIT
    q1.delete(); q0.delete();
    load(tbl[2]);
    TP_IRQ = 1'b0;
    wait_done(ok);
    chk("wait-rel done", 32'(ok), 1);
    chk("wait-rel data", oData, tbl[2].exp);
    pc = pu_cnt;
    TP_IRQ = 1'b1;
    n = 0;
    while (!oPenUp && n < 10) begin tick(); n++; end
    chk("wait-rel latency ok", 32'(oPenUp && n <= 3), 1);
    tick(10);
    chk("wait-rel pendown", oPenDown, 0);
    chk("wait-rel one pulse", pu_cnt - pc, 1);

    // Disable during WAIT
    q1.delete(); q0.delete();
    load(tbl[3]);
    TP_IRQ = 1'b0;
    wait_done(ok);
    chk("dis done", 32'(ok), 1);
    chk("dis data", oData, tbl[3].exp);
    iEn = 1'b0;
    pc = pu_cnt;
    tick(2);
    chk("dis pendown", oPenDown, 0);
    sz = req_log.size();
    tick(30);
    chk("dis no penup", pu_cnt - pc, 0);
    chk("dis no call", req_log.size() - sz, 0);
    chk("dis stays up", oPenDown, 0);

    // Asynchronous reset with a request outstanding
    iEn = 1'b1;
    cyc_to_call(n);
    chk("pre-reset call", 32'(bus.oCall != 2'b00), 1);
    tick(1);
    #2 RESET = 1'b0;
    #1;
    chk("mid-reset oCall", bus.oCall, 0);
    chk("mid-reset oData", oData, 0);
    chk("mid-reset oPenDown", oPenDown, 0);
    chk("mid-reset oDone", oDone, 0);
    chk("mid-reset oPenUp", oPenUp, 0);
    tick(2);
    RESET = 1'b1;
    cyc_to_call(n);
    chk("post-reset latency", n, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
